ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequential arbiter that shares the single SDRAM-backed byte port (`sram`) between the four memory masters of the Spectrum core: ioctl DMA, CPU, FDC buffer reads and tape buffer reads. Replaces combinational address/strobe muxing with a request/acknowledge scheduler. The scheduler uses fixed priority, a starvation guard for the low-priority readers, one outstanding access at a time, and safe recovery from reset during an access. It sits between the requester logic in the top level and the `sram` controller.

## Interface
- `AW`, 25: byte address width.
- `STARVE`, 15: wait count, in arbitration cycles, after which FDC or tape is promoted above the CPU. Range 1..15.

- `clk_sys`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `dma_req`, `cpu_req`, `fdd_req`, `tape_req`  in  1 each  level request; held until the matching ack.
- `dma_addr`, `cpu_addr`, `fdd_addr`, `tape_addr`  in  AW each  byte address; stable while req is high.
- `dma_we`, `cpu_we`  in  1 each  1 = write, 0 = read. FDC and tape are read-only.
- `dma_din`, `cpu_din`  in  8 each  write data.
- `dma_ack`, `cpu_ack`, `fdd_ack`, `tape_ack`  out  1 each  one-cycle completion pulse.
- `rd_data`  out  8  registered read data; valid in the ack cycle and held until the next read completes.
- `grant`  out  2  current or last owner: 0 = dma, 1 = cpu, 2 = fdd, 3 = tape.
- `busy`  out  1  high in every state except IDLE.
- `mem_addr`  out  AW  latched command address.
- `mem_din`  out  8  latched write data.
- `mem_we`, `mem_rd`  out  1 each  command type, held from ISSUE through WAIT.
- `mem_start`  out  1  one-cycle command strobe.
- `mem_dout`  in  8  back-end read data, valid with `mem_done`.
- `mem_done`  in  1  one-cycle back-end completion pulse.

## Operation
States: IDLE, ISSUE, WAIT, DONE, DRAIN.

- **IDLE.** If any req is high, select the winner and latch its addr, din, we and id. Go to ISSUE. Otherwise stay in IDLE.
- **ISSUE.** Assert `mem_start` for one cycle with `mem_we` = latched we and `mem_rd` = ~latched we. Go to WAIT.
- **WAIT.** Hold the command outputs. On `mem_done`, capture `mem_dout` into `rd_data` (reads only) and go to DONE.
- **DONE.** Pulse the winner's ack, drop `mem_we`/`mem_rd`, and go to IDLE.
- **DRAIN.** Issue nothing. On `mem_done`, go to IDLE and discard the data.

Selection order:
1. dma.
2. Starved fdd.
3. Starved tape.
4. cpu.
5. fdd.
6. tape.

Starvation counters:
- fdd and tape each have a 4-bit wait counter.
- In IDLE, when that requester's req is high and it loses selection, its counter increments, saturating at 15.
- The counter clears when that requester is granted or when its req is low.
- A requester is starved when its counter is ≥ STARVE.
- dma is never overridden.

Other rules:
- Writes leave `rd_data` unchanged.
- Req high in the cycle after its ack is a new request and competes normally. The ack cycle itself is not re-sampled.
- Req dropped while the requester's access is in flight: the access completes and the ack still pulses. The requester ignores it.
- `mem_done` outside WAIT/DRAIN is ignored.

Reset values:
- All acks, `mem_start`, `mem_we`, `mem_rd` and `busy` are 0.
- `grant`, `rd_data`, `mem_addr`, `mem_din` and both counters are 0.
- Next state is IDLE, except when reset is sampled while in ISSUE or WAIT: the next state is then DRAIN, with `busy` = 1. This is so a back-end access already started is never overlapped. `mem_we` and `mem_rd` still drop to 0.
- Reset held across `mem_done` while in DRAIN: the next state is IDLE.

## Timing
- Request sampled in IDLE at cycle N.
- `mem_start` at N+1.
- `mem_done` at the earliest at N+2, in general at cycle M.
- Ack and valid `rd_data` at M+1.
- IDLE at M+2. A new request can be sampled at M+2.
- Minimum access is 4 cycles; back-to-back throughput is 1 access per 4 cycles with a zero-latency back-end.
- `grant` updates in the cycle after selection, i.e. with ISSUE.
- `mem_addr`/`mem_din` are stable from ISSUE until the next selection.
- Simultaneous requests in one IDLE cycle: exactly one is granted. Losers keep req high and are re-evaluated at the next IDLE.
- `mem_done` and `reset` in the same WAIT cycle: reset wins, next state is DRAIN, and that `mem_done` is not counted. DRAIN then waits for a further `mem_done`. The back-end must be reset with the same signal, or the system accepts the stall.

## Test plan
- Single CPU read at 0x0A000, back-end done 3 cycles after start: `mem_start` at N+1, `mem_rd` = 1, `mem_addr` = 0x0A000. `cpu_ack` and `rd_data` = `mem_dout` (0x5A) appear 1 cycle after `mem_done`.
- dma, cpu, fdd and tape all raise req in the same cycle and hold it: grant order is 0, 1, 1, 1… while the CPU keeps re-requesting, until fdd is promoted.
- CPU re-requests continuously with STARVE = 3 while fdd and tape wait: fdd is granted after its counter reaches 3, tape after its counter reaches 3 with the fdd counter cleared, and the CPU never waits more than 2 accesses.
- DMA write 0x3C to 0x181FFF: `mem_we` = 1, `mem_din` = 0x3C, `dma_ack` pulses, and `rd_data` holds its previous value.
- Reset asserted in WAIT for 1 cycle: all outputs except `busy` are 0, state is DRAIN, and no `mem_start` occurs while `cpu_req` is high. After `mem_done`, IDLE is reached and the CPU request is granted 1 cycle later.
- `mem_done` pulsed while in IDLE with no requests: no ack, no state change, `rd_data` unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Request/acknowledge scheduler that shares the single SDRAM-backed byte port
// between the four memory masters of the Spectrum core: ioctl DMA, CPU,
// FDC buffer reads and tape buffer reads. Only one access is outstanding at a
// time. Arbitration is fixed-priority with a starvation guard that lifts a
// long-waiting FDC or tape reader above the CPU. A reset that lands while a
// back-end access is in flight parks the arbiter in DRAIN until that access
// reports completion, so the back-end never sees overlapping commands.
//
// Parameters
//   AW      byte address width
//   STARVE  IDLE-cycle losses after which FDC/tape outrank the CPU (1..15)
//
// Ports
//   clk_sys                 system clock, all logic on the rising edge
//   reset                   synchronous, active-high
//   dma_req/cpu_req/
//   fdd_req/tape_req        level requests, held until the matching ack
//   *_addr                  byte address per requester, stable while req high
//   dma_we/cpu_we           1 = write, 0 = read (FDC and tape only read)
//   dma_din/cpu_din         write data
//   *_ack                   one-cycle completion pulse per requester
//   rd_data                 last read byte, valid from the ack cycle onward
//   grant                   current/last owner: 0 dma, 1 cpu, 2 fdd, 3 tape
//   busy                    high whenever the scheduler is not IDLE
//   mem_addr/mem_din        latched command address and write data
//   mem_we/mem_rd           command type, held from ISSUE through WAIT
//   mem_start               one-cycle command strobe to the back-end
//   mem_dout/mem_done       back-end read data and completion pulse
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int AW     = 25,
  parameter int STARVE = 15
) (
  input  logic          clk_sys,
  input  logic          reset,

  input  logic          dma_req,
  input  logic          cpu_req,
  input  logic          fdd_req,
  input  logic          tape_req,

  input  logic [AW-1:0] dma_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] fdd_addr,
  input  logic [AW-1:0] tape_addr,

  input  logic          dma_we,
  input  logic          cpu_we,
  input  logic [7:0]    dma_din,
  input  logic [7:0]    cpu_din,

  output logic          dma_ack,
  output logic          cpu_ack,
  output logic          fdd_ack,
  output logic          tape_ack,

  output logic [7:0]    rd_data,
  output logic [1:0]    grant,
  output logic          busy,

  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  output logic          mem_start,
  input  logic [7:0]    mem_dout,
  input  logic          mem_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ID_DMA  = 2'd0;
  localparam logic [1:0] ID_CPU  = 2'd1;
  localparam logic [1:0] ID_FDD  = 2'd2;
  localparam logic [1:0] ID_TAPE = 2'd3;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);
  localparam logic [3:0] WAIT_MAX   = 4'hF;

  state_t        r_state;
  state_t        w_nextState;

  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic          r_we;
  logic [1:0]    r_grant;
  logic [7:0]    r_rdData;
  logic [3:0]    r_fddWait;
  logic [3:0]    r_tapeWait;

  logic          w_anyReq;
  logic          w_select;
  logic          w_fddStarved;
  logic          w_tapeStarved;
  logic [1:0]    w_winner;
  logic [AW-1:0] w_selAddr;
  logic [7:0]    w_selDin;
  logic          w_selWe;

  assign w_anyReq      = dma_req | cpu_req | fdd_req | tape_req;
  assign w_select      = (r_state == ST_IDLE) && w_anyReq;
  assign w_fddStarved  = (r_fddWait  >= STARVE_LIM);
  assign w_tapeStarved = (r_tapeWait >= STARVE_LIM);

  // Fixed-priority selection. DMA is never overridden; a starved FDC or tape
  // reader jumps ahead of the CPU, FDC being checked before tape.
  always_comb begin
    w_winner = ID_DMA;
    if (dma_req)
      w_winner = ID_DMA;
    else if (fdd_req && w_fddStarved)
      w_winner = ID_FDD;
    else if (tape_req && w_tapeStarved)
      w_winner = ID_TAPE;
    else if (cpu_req)
      w_winner = ID_CPU;
    else if (fdd_req)
      w_winner = ID_FDD;
    else if (tape_req)
      w_winner = ID_TAPE;
  end

  // Command fields of the winner. FDC and tape are read-only, so their write
  // data is forced to zero rather than left floating in the latch.
  always_comb begin
    w_selAddr = dma_addr;
    w_selDin  = dma_din;
    w_selWe   = dma_we;
    case (w_winner)
      ID_CPU: begin
        w_selAddr = cpu_addr;
        w_selDin  = cpu_din;
        w_selWe   = cpu_we;
      end
      ID_FDD: begin
        w_selAddr = fdd_addr;
        w_selDin  = 8'h00;
        w_selWe   = 1'b0;
      end
      ID_TAPE: begin
        w_selAddr = tape_addr;
        w_selDin  = 8'h00;
        w_selWe   = 1'b0;
      end
      default: ;
    endcase
  end

  // State register. Reset during ISSUE or WAIT means the back-end may already
  // be working on a command, so we wait in DRAIN for its completion instead of
  // returning straight to IDLE. A reset sampled in DRAIN only lets go once the
  // outstanding mem_done arrives.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      case (r_state)
        ST_ISSUE, ST_WAIT: r_state <= ST_DRAIN;
        ST_DRAIN:          r_state <= mem_done ? ST_IDLE : ST_DRAIN;
        default:           r_state <= ST_IDLE;
      endcase
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and command/ack outputs. The ack cycle (DONE) always returns
  // to IDLE, so a requester still holding req during its ack is not counted
  // again; it competes afresh from the following IDLE cycle.
  always_comb begin
    w_nextState = r_state;
    mem_start   = 1'b0;
    mem_we      = 1'b0;
    mem_rd      = 1'b0;
    dma_ack     = 1'b0;
    cpu_ack     = 1'b0;
    fdd_ack     = 1'b0;
    tape_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyReq)
          w_nextState = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_start   = 1'b1;
        mem_we      = r_we;
        mem_rd      = ~r_we;
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        mem_we = r_we;
        mem_rd = ~r_we;
        if (mem_done)
          w_nextState = ST_DONE;
      end
      ST_DONE: begin
        case (r_grant)
          ID_DMA:  dma_ack  = 1'b1;
          ID_CPU:  cpu_ack  = 1'b1;
          ID_FDD:  fdd_ack  = 1'b1;
          default: tape_ack = 1'b1;
        endcase
        w_nextState = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_done)
          w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Command latch and read-data capture. The latch only moves on a new
  // selection, which keeps mem_addr/mem_din steady across the whole access
  // and afterwards until the next grant.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_addr   <= '0;
      r_din    <= 8'h00;
      r_we     <= 1'b0;
      r_grant  <= ID_DMA;
      r_rdData <= 8'h00;
    end else begin
      if (w_select) begin
        r_addr  <= w_selAddr;
        r_din   <= w_selDin;
        r_we    <= w_selWe;
        r_grant <= w_winner;
      end
      if ((r_state == ST_WAIT) && mem_done && !r_we)
        r_rdData <= mem_dout;
    end
  end

  // Starvation ages for the two low-priority readers. They only grow on IDLE
  // cycles where the reader asked and lost, so the count is in arbitration
  // rounds rather than clock cycles, and they saturate instead of wrapping.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_fddWait  <= 4'd0;
      r_tapeWait <= 4'd0;
    end else begin
      if (!fdd_req)
        r_fddWait <= 4'd0;
      else if (r_state == ST_IDLE) begin
        if (w_winner == ID_FDD)
          r_fddWait <= 4'd0;
        else if (r_fddWait != WAIT_MAX)
          r_fddWait <= r_fddWait + 4'd1;
      end

      if (!tape_req)
        r_tapeWait <= 4'd0;
      else if (r_state == ST_IDLE) begin
        if (w_winner == ID_TAPE)
          r_tapeWait <= 4'd0;
        else if (r_tapeWait != WAIT_MAX)
          r_tapeWait <= r_tapeWait + 4'd1;
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign grant    = r_grant;
  assign rd_data  = r_rdData;
  assign mem_addr = r_addr;
  assign mem_din  = r_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Self-checking bench for ram_arbiter. A transaction-level model keeps the
// pending request of each master, the two starvation ages and the expected
// read-data register; each access is driven from IDLE through ISSUE, WAIT
// and DONE with the back-end completion supplied by the bench.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int AW     = 25;
  localparam int STARVE = 3;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          dma_req = 1'b0, cpu_req = 1'b0, fdd_req = 1'b0, tape_req = 1'b0;
  logic [AW-1:0] dma_addr = '0, cpu_addr = '0, fdd_addr = '0, tape_addr = '0;
  logic          dma_we = 1'b0, cpu_we = 1'b0;
  logic [7:0]    dma_din = 8'h00, cpu_din = 8'h00;
  logic          dma_ack, cpu_ack, fdd_ack, tape_ack;
  logic [7:0]    rd_data;
  logic [1:0]    grant;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we, mem_rd, mem_start;
  logic [7:0]    mem_dout = 8'h00;
  logic          mem_done = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ram_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dma_req(dma_req), .cpu_req(cpu_req), .fdd_req(fdd_req), .tape_req(tape_req),
    .dma_addr(dma_addr), .cpu_addr(cpu_addr), .fdd_addr(fdd_addr), .tape_addr(tape_addr),
    .dma_we(dma_we), .cpu_we(cpu_we), .dma_din(dma_din), .cpu_din(cpu_din),
    .dma_ack(dma_ack), .cpu_ack(cpu_ack), .fdd_ack(fdd_ack), .tape_ack(tape_ack),
    .rd_data(rd_data), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_start(mem_start), .mem_dout(mem_dout), .mem_done(mem_done)
  );

  // Reference model state: one outstanding request per master (0 dma, 1 cpu,
  // 2 fdd, 3 tape), starvation ages in arbitration rounds, expected rd_data.
  logic          pend    [4];
  logic [AW-1:0] reqAddr [4];
  logic          reqWe   [4];
  logic [7:0]    reqDin  [4];
  int            waitFdd  = 0;
  int            waitTape = 0;
  logic [7:0]    expRd    = 8'h00;
  int            dutGrants[$];
  int            expOrder [6] = '{0, 1, 1, 2, 3, 1};

  int assertCount = 0;
  int failCount   = 0;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    dma_req   = pend[0];    cpu_req  = pend[1];
    fdd_req   = pend[2];    tape_req = pend[3];
    dma_addr  = reqAddr[0]; cpu_addr = reqAddr[1];
    fdd_addr  = reqAddr[2]; tape_addr = reqAddr[3];
    dma_we    = reqWe[0];   cpu_we   = reqWe[1];
    dma_din   = reqDin[0];  cpu_din  = reqDin[1];
  endtask

  task automatic newRequest(input int id, input logic [AW-1:0] addr,
                            input logic we, input logic [7:0] din);
    pend[id]    = 1'b1;
    reqAddr[id] = addr;
    reqWe[id]   = (id < 2) ? we : 1'b0;
    reqDin[id]  = (id < 2) ? din : 8'h00;
  endtask

  function automatic logic [3:0] ackVec();
    return {tape_ack, fdd_ack, cpu_ack, dma_ack};
  endfunction

  // Selection order written straight from the priority list.
  function automatic int pickWinner();
    if (pend[0])                      return 0;
    if (pend[2] && waitFdd  >= STARVE) return 2;
    if (pend[3] && waitTape >= STARVE) return 3;
    if (pend[1])                      return 1;
    if (pend[2])                      return 2;
    if (pend[3])                      return 3;
    return -1;
  endfunction

  function automatic int age(input int a);
    return (a < 15) ? a + 1 : 15;
  endfunction

  // One complete access starting in an IDLE cycle with at least one request
  // pending; latency is the number of WAIT cycles before mem_done.
  task automatic doAccess(input int latency, input logic [7:0] dout);
    int w;
    applyStimulus();
    w = pickWinner();
    waitFdd  = (pend[2] && w != 2) ? age(waitFdd)  : 0;
    waitTape = (pend[3] && w != 3) ? age(waitTape) : 0;
    step();
    dutGrants.push_back(int'(grant));
    checkOutput("issue.mem_start", mem_start, 1);
    checkOutput("issue.grant", grant, w);
    checkOutput("issue.mem_addr", mem_addr, reqAddr[w]);
    checkOutput("issue.mem_we", mem_we, reqWe[w]);
    checkOutput("issue.mem_rd", mem_rd, !reqWe[w]);
    if (reqWe[w]) checkOutput("issue.mem_din", mem_din, reqDin[w]);
    checkOutput("issue.busy", busy, 1);
    step();
    checkOutput("wait.mem_start", mem_start, 0);
    checkOutput("wait.mem_rd", mem_rd, !reqWe[w]);
    for (int i = 0; i < latency; i++) begin
      step();
      checkOutput("wait.acks", ackVec(), 0);
    end
    mem_done = 1'b1;
    mem_dout = dout;
    step();
    mem_done = 1'b0;
    mem_dout = 8'($urandom);
    if (!reqWe[w]) expRd = dout;
    checkOutput("done.acks", ackVec(), 4'b0001 << w);
    checkOutput("done.rd_data", rd_data, expRd);
    checkOutput("done.we_rd", {mem_we, mem_rd}, 0);
    checkOutput("done.mem_addr", mem_addr, reqAddr[w]);
    step();
    pend[w] = 1'b0;
    applyStimulus();
    checkOutput("idle.busy", busy, 0);
    checkOutput("idle.acks", ackVec(), 0);
  endtask

  task automatic modelReset();
    waitFdd  = 0;
    waitTape = 0;
    expRd    = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; reqAddr[i] = '0; reqWe[i] = 1'b0; reqDin[i] = 8'h00;
    end

    // Reset state.
    applyStimulus();
    repeat (3) step();
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.acks", ackVec(), 0);
    checkOutput("reset.cmd", {mem_start, mem_we, mem_rd}, 0);
    checkOutput("reset.grant", grant, 0);
    checkOutput("reset.rd_data", rd_data, 0);
    checkOutput("reset.mem_addr", mem_addr, 0);
    checkOutput("reset.mem_din", mem_din, 0);
    reset = 1'b0;
    step();

    // Single CPU read, back-end done 3 cycles after mem_start.
    $display("[TB] cpu read");
    newRequest(1, 25'h000A000, 1'b0, 8'h00);
    doAccess(2, 8'h5A);

    // DMA write leaves rd_data alone.
    $display("[TB] dma write");
    newRequest(0, 25'h0181FFF, 1'b1, 8'h3C);
    doAccess(1, 8'hA7);

    // mem_done while IDLE with nothing requested is ignored.
    $display("[TB] stray mem_done");
    mem_done = 1'b1; mem_dout = 8'hEE;
    step();
    mem_done = 1'b0;
    checkOutput("stray.busy", busy, 0);
    checkOutput("stray.acks", ackVec(), 0);
    checkOutput("stray.rd_data", rd_data, expRd);
    step();
    checkOutput("stray.mem_start", mem_start, 0);

    // All four request together; the CPU keeps re-requesting.
    $display("[TB] four-way contention");
    newRequest(0, 25'h0000100, 1'b1, 8'h11);
    newRequest(1, 25'h0000200, 1'b0, 8'h00);
    newRequest(2, 25'h0000300, 1'b0, 8'h00);
    newRequest(3, 25'h0000400, 1'b0, 8'h00);
    dutGrants.delete();
    for (int i = 0; i < 6; i++) begin
      doAccess(i % 3, 8'($urandom));
      if (!pend[1]) newRequest(1, 25'h0000200 + 25'(i), 1'b0, 8'h00);
    end
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("order.%0d", i), dutGrants[i], expOrder[i]);
    pend[1] = 1'b0;
    applyStimulus();
    step();

    // One-cycle reset in WAIT: DRAIN until mem_done, then the CPU is served.
    $display("[TB] reset during wait");
    newRequest(1, 25'h0012345, 1'b0, 8'h00);
    applyStimulus();
    step();
    checkOutput("rstw.issue", mem_start, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    modelReset();
    checkOutput("rstw.busy", busy, 1);
    checkOutput("rstw.cmd", {mem_start, mem_we, mem_rd}, 0);
    checkOutput("rstw.grant", grant, 0);
    checkOutput("rstw.mem_addr", mem_addr, 0);
    checkOutput("rstw.mem_din", mem_din, 0);
    checkOutput("rstw.rd_data", rd_data, 0);
    checkOutput("rstw.acks", ackVec(), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rstw.drain_start", mem_start, 0);
      checkOutput("rstw.drain_busy", busy, 1);
    end
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    checkOutput("rstw.idle_busy", busy, 0);
    checkOutput("rstw.idle_acks", ackVec(), 0);
    doAccess(0, 8'hC3);

    // Reset together with mem_done in WAIT: that done is not counted.
    $display("[TB] reset with mem_done");
    newRequest(0, 25'h1000001, 1'b1, 8'h77);
    applyStimulus();
    step();
    step();
    reset = 1'b1; mem_done = 1'b1;
    step();
    reset = 1'b0; mem_done = 1'b0;
    modelReset();
    checkOutput("rstd.busy", busy, 1);
    step();
    checkOutput("rstd.still_drain", busy, 1);
    checkOutput("rstd.no_start", mem_start, 0);
    reset = 1'b1; mem_done = 1'b1;
    step();
    reset = 1'b0; mem_done = 1'b0;
    checkOutput("rstd.idle", busy, 0);
    doAccess(1, 8'h99);

    // Randomised traffic against the model.
    $display("[TB] random traffic");
    for (int it = 0; it < 60; it++) begin
      for (int id = 0; id < 4; id++)
        if (!pend[id] && $urandom_range(0, 2) == 0)
          newRequest(id, AW'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      if (pend[0] || pend[1] || pend[2] || pend[3])
        doAccess(int'($urandom_range(0, 3)), 8'($urandom));
      else begin
        applyStimulus();
        step();
        checkOutput("rand.idle", busy, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
